// File: rtl/mem_stage_unit.sv
// Memory-access pipeline stage: byte-lane data RAM with sign/zero-extended loads,
// registered valid/ready result and alignment/range error detection.
module mem_stage_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_we,
  output logic            out_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned AW = IW + OW;
  localparam logic [NB-1:0] BeByte = NB'(1);
  localparam logic [NB-1:0] BeHalf = NB'(3);

  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic            is_store;
  logic            is_uns;
  logic [1:0]      size;
  logic [OW-1:0]   off;
  logic [IW-1:0]   idx;
  logic [OW+2:0]   lane_shift;
  logic            err;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rword_sh;
  logic [XLEN-1:0] rdata_ext;
  logic            mem_we;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign is_store   = in_op[3];
  assign is_uns     = in_op[2];
  assign size       = in_op[1:0];
  assign off        = in_addr[OW-1:0];
  assign idx        = in_addr[AW-1:OW];
  assign lane_shift = {off, 3'b000};
  assign wdata_sh   = in_wdata << lane_shift;
  assign rword_sh   = mem[idx] >> lane_shift;
  assign mem_we     = accept && is_store && !err;

  always_comb begin
    err       = (in_addr >> AW) != '0;
    be        = '0;
    rdata_ext = '0;
    case (size)
      2'b00: begin
        be        = BeByte << off;
        rdata_ext = is_uns ? {{(XLEN-8){1'b0}}, rword_sh[7:0]}
                           : {{(XLEN-8){rword_sh[7]}}, rword_sh[7:0]};
      end
      2'b01: begin
        if (in_addr[0]) err = 1'b1;
        be        = BeHalf << off;
        rdata_ext = is_uns ? {{(XLEN-16){1'b0}}, rword_sh[15:0]}
                           : {{(XLEN-16){rword_sh[15]}}, rword_sh[15:0]};
      end
      2'b10: begin
        if (off != '0) err = 1'b1;
        be        = '1;
        // Shift is zero for any aligned word, so this is the raw word.
        rdata_ext = rword_sh;
      end
      default: err = 1'b1;
    endcase
  end

  // RAM is deliberately not reset so stored data survives rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_rdata <= '0;
      out_we    <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rd    <= in_rd;
      out_err   <= err;
      out_we    <= !is_store && !err;
      out_rdata <= (!is_store && !err) ? rdata_ext : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed, table-driven bench for mem_stage_unit plus back-pressure and reset sequences.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_rdata;
  logic        out_we;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.XLEN(32), .DEPTH(256), .RD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_rdata (out_rdata),
    .out_we    (out_we),
    .out_err   (out_err)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic ev, input logic [4:0] erd,
                     input logic [31:0] edata, input logic ewe, input logic eerr);
    checks++;
    if (out_valid !== ev || out_rd !== erd || out_rdata !== edata || out_we !== ewe ||
        out_err !== eerr) begin
      errors++;
      $display("FAIL %s: got valid=%b rd=%0d rdata=%h we=%b err=%b, want valid=%b rd=%0d rdata=%h we=%b err=%b",
               name, out_valid, out_rd, out_rdata, out_we, out_err, ev, erd, edata, ewe, eerr);
    end
  endtask

  task automatic chk_ready(input string name, input logic exp);
    checks++;
    if (in_ready !== exp) begin
      errors++;
      $display("FAIL %s: in_ready got %b want %b", name, in_ready, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wdata;
    in_rd    = rd;
  endtask

  initial begin
    // op: [3]=store [2]=unsigned [1:0]=size
    vecs.push_back('{"st_w_10",     4'b1010, 32'h10,  32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ld_w_10",     4'b0010, 32'h10,  32'h0,        5'd3,  32'hDEADBEEF, 1'b1, 1'b0});
    vecs.push_back('{"st_b_11",     4'b1000, 32'h11,  32'h0000007F, 5'd2,  32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ld_sb_12",    4'b0000, 32'h12,  32'h0,        5'd4,  32'hFFFFFFAD, 1'b1, 1'b0});
    vecs.push_back('{"ld_uh_10",    4'b0101, 32'h10,  32'h0,        5'd5,  32'h00007FEF, 1'b1, 1'b0});
    vecs.push_back('{"ld_w_10b",    4'b0010, 32'h10,  32'h0,        5'd6,  32'hDEAD7FEF, 1'b1, 1'b0});
    vecs.push_back('{"ld_h_odd",    4'b0001, 32'h13,  32'h0,        5'd7,  32'h0,        1'b0, 1'b1});
    vecs.push_back('{"st_w_mis",    4'b1010, 32'h12,  32'h12345678, 5'd8,  32'h0,        1'b0, 1'b1});
    vecs.push_back('{"ld_w_unch",   4'b0010, 32'h10,  32'h0,        5'd9,  32'hDEAD7FEF, 1'b1, 1'b0});
    vecs.push_back('{"st_w_00",     4'b1010, 32'h0,   32'h55555555, 5'd1,  32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ld_w_oor",    4'b0010, 32'h400, 32'h0,        5'd10, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"st_w_oor",    4'b1010, 32'h400, 32'hAAAAAAAA, 5'd11, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"ld_w_00",     4'b0010, 32'h0,   32'h0,        5'd12, 32'h55555555, 1'b1, 1'b0});
    vecs.push_back('{"ld_sz11",     4'b0011, 32'h10,  32'h0,        5'd13, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"st_sz11",     4'b1011, 32'h10,  32'h0,        5'd14, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"ld_w_unch2",  4'b0010, 32'h10,  32'h0,        5'd15, 32'hDEAD7FEF, 1'b1, 1'b0});
    vecs.push_back('{"ld_sh_12",    4'b0001, 32'h12,  32'h0,        5'd16, 32'hFFFFDEAD, 1'b1, 1'b0});
    vecs.push_back('{"ld_ub_13",    4'b0100, 32'h13,  32'h0,        5'd17, 32'h000000DE, 1'b1, 1'b0});
    vecs.push_back('{"ld_sb_11",    4'b0000, 32'h11,  32'h0,        5'd18, 32'h0000007F, 1'b1, 1'b0});
    vecs.push_back('{"st_w_14",     4'b1010, 32'h14,  32'h0,        5'd19, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"st_h_16",     4'b1001, 32'h16,  32'h00008001, 5'd20, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ld_w_14",     4'b0010, 32'h14,  32'h0,        5'd21, 32'h80010000, 1'b1, 1'b0});
    vecs.push_back('{"st_w_uns_18", 4'b1110, 32'h18,  32'hCAFEF00D, 5'd22, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ld_w_18",     4'b0010, 32'h18,  32'h0,        5'd23, 32'hCAFEF00D, 1'b1, 1'b0});
    vecs.push_back('{"ld_w_uns_10", 4'b0110, 32'h10,  32'h0,        5'd24, 32'hDEAD7FEF, 1'b1, 1'b0});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_addr   = '0;
    in_wdata  = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    #12;
    chk("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk_ready("reset_ready", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      set_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk(vecs[i].name, 1'b1, vecs[i].rd, vecs[i].exp_rdata, vecs[i].exp_we, vecs[i].exp_err);
    end

    // Back-pressure: result held while out_ready=0, queued request waits.
    @(negedge clk);
    set_req(4'b0010, 32'h10, 32'h0, 5'd7);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_req(4'b0010, 32'h14, 32'h0, 5'd8);
    #1;
    chk_ready("bp_ready_low", 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_%0d", c), 1'b1, 5'd7, 32'hDEAD7FEF, 1'b1, 1'b0);
      chk_ready($sformatf("bp_ready_%0d", c), 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk_ready("bp_release_ready", 1'b1);
    @(posedge clk);
    #1;
    chk("bp_queued", 1'b1, 5'd8, 32'h80010000, 1'b1, 1'b0);
    set_req(4'b0010, 32'h18, 32'h0, 5'd9);
    @(posedge clk);
    #1;
    chk("stream_0", 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 1'b0);
    set_req(4'b0010, 32'h0, 32'h0, 5'd10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stream_1", 1'b1, 5'd10, 32'h55555555, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("drain", 1'b0, 5'd10, 32'h55555555, 1'b1, 1'b0);

    // Asynchronous reset while a result is pending.
    set_req(4'b0010, 32'h10, 32'h0, 5'd11);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_reset", 1'b1, 5'd11, 32'hDEAD7FEF, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_req(4'b0010, 32'h18, 32'h0, 5'd12);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_reset_ld", 1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Parametrised memory-access pipeline stage between execute and writeback.
- Accepts one load or store per handshake and stores into an internal word-organised data RAM with byte lanes.
- Returns load data, sign- or zero-extended, through a registered valid/ready output with an error flag.
- Successor to the fixed 32x32, store-only, unhandshaked memory stage: adds width/depth parameters, loads, sub-word access, back-pressure and error detection.

Parameters:
XLEN, 32, data width in bits; multiple of 8, minimum 16.
DEPTH, 256, number of XLEN-bit words in the data RAM; power of two.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  stage can accept a request this cycle.
in_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal).
in_addr  in  XLEN  byte address.
in_wdata  in  XLEN  store data; low bytes used for sub-word stores.
in_rd  in  RD_W  destination register for the load result.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_rd  out  RD_W  destination register, passed through.
out_rdata  out  XLEN  extended load data; 0 for stores and errors.
out_we  out  1  1 = writeback required (a load with no error).
out_err  out  1  misaligned, illegal size, or out-of-range address.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_rd=0, out_rdata=0, out_we=0, out_err=0. RAM contents are not reset and are retained across reset.
- in_ready = !out_valid || out_ready (single output register; no combinational path from in_valid to in_ready).
- A request is accepted on a rising edge with in_valid && in_ready. The result appears in the output register on that same edge: latency 1 cycle; throughput 1 request per cycle while out_ready=1.
- If out_valid=1 and out_ready=0, the outputs hold stable and no request is accepted.
- Word index = in_addr[log2(DEPTH)+log2(XLEN/8)-1 : log2(XLEN/8)]. Lane offset = the low log2(XLEN/8) bits.
- Error conditions (set out_err=1, out_we=0, out_rdata=0, and write no RAM byte):
  - size=11.
  - Halfword access at an odd address.
  - Word access with a nonzero lane offset.
  - Any in_addr bit above the word-index field set (out of range).
- Store without error: write only the addressed bytes (1, 2 or XLEN/8 lanes) at the accept edge. Other bytes are unchanged. Result: out_we=0, out_err=0, out_rdata=0. out_valid is still asserted so the store retires in order.
- Load without error: read at the accept edge.
  - Select the lanes by offset.
  - Sign-extend from bit 7/15 when in_op[2]=0; zero-extend when in_op[2]=1.
  - Word loads ignore in_op[2].
  - out_we=1.
- Read-after-write: a load accepted on the edge after a store to the same word sees the new data. Only one request per cycle, so there is no same-edge conflict.
- in_op[2] is ignored for stores.
- out_rd is captured for every accepted request.
- Reset asserted mid-operation: a pending output is dropped (out_valid=0). A store already written before reset stays in RAM.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word from 0x10 on the next cycle, rd=3 -> out_rdata=0xDEADBEEF, out_we=1, out_rd=3, out_err=0.
- After the above: store byte 0x7F at 0x11, then signed byte load at 0x12 -> 0xFFFFFFAD; unsigned half load at 0x10 -> 0x00007FEF; word load at 0x10 -> 0xDEAD7FEF.
- Half load at 0x13, and separately word store at 0x12 -> out_err=1, out_we=0, out_rdata=0; a following word load at 0x10 shows the RAM unchanged.
- Address 0x400 with DEPTH=256, and separately size=11 -> out_err=1, no RAM write.
- Hold out_ready=0 for 3 cycles with a load pending -> in_ready=0, outputs stable. Release -> the next queued request is accepted on that same edge; back-to-back loads then stream one per cycle.
- Assert rst_n=0 while out_valid=1 -> out_valid drops immediately, without a clock edge. After release, a load of a previously stored word returns the stored value.
